// File: rtl/pair_pattern_driver_if.sv
// Bundle of table-load, playback-control and driven-pair signals for pair_pattern_driver.
// The master side is the controller or bench; the slave side is the pattern driver.
interface pair_pattern_driver_if #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8,
    parameter int REP_W   = 4
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic               wr_valid;
    logic               wr_ready;
    logic               wr_a;
    logic               wr_b;
    logic [DWELL_W-1:0] wr_dwell;
    logic               clear;
    logic               start;
    logic [REP_W-1:0]   repeat_cnt;
    logic               stop;
    logic               a_out;
    logic               b_out;
    logic               eq_out;
    logic               busy;
    logic [IDX_W-1:0]   step_idx;
    logic [CNT_W-1:0]   count;
    logic               done;
    logic               aborted;
    logic               err_empty;

    modport master (
        output wr_valid, wr_a, wr_b, wr_dwell, clear, start, repeat_cnt, stop,
        input  wr_ready, a_out, b_out, eq_out, busy, step_idx, count,
               done, aborted, err_empty
    );

    modport slave (
        input  wr_valid, wr_a, wr_b, wr_dwell, clear, start, repeat_cnt, stop,
        output wr_ready, a_out, b_out, eq_out, busy, step_idx, count,
               done, aborted, err_empty
    );
endinterface

// File: rtl/pair_pattern_driver.sv
// Plays a loaded table of (a, b, dwell) steps onto a registered output pair.
// a_out, b_out and eq_out are updated together so a downstream a==b checker never sees skew.
module pair_pattern_driver #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8,
    parameter int REP_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pair_pattern_driver_if.slave  bus
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_W   = IDX_W + 1;
    localparam int ENTRY_W = 2 + DWELL_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   step_idx_q, step_idx_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               eq_q, eq_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [REP_W-1:0]   passes_q, passes_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               err_empty_q, err_empty_d;

    logic [ENTRY_W-1:0] table_mem [DEPTH];

    logic               wr_ready;
    logic               wr_fire;
    logic [CNT_W-1:0]   next_idx;
    logic [ENTRY_W-1:0] entry_first;
    logic [ENTRY_W-1:0] entry_next;
    logic               do_load;
    logic [IDX_W-1:0]   ld_idx;
    logic [ENTRY_W-1:0] ld_entry;

    assign wr_ready = (state_q == S_IDLE) && !bus.start && (count_q < DEPTH_C);
    // clear in the same cycle as a write drops the write
    assign wr_fire  = wr_ready && bus.wr_valid && !bus.clear;
    assign next_idx = {1'b0, step_idx_q} + CNT_W'(1);

    // Both possible next steps are read up front so the FSM picks between them without a loop.
    assign entry_first = table_mem[0];
    assign entry_next  = table_mem[next_idx[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            table_mem[count_q[IDX_W-1:0]] <= {bus.wr_a, bus.wr_b, bus.wr_dwell};
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        step_idx_d  = step_idx_q;
        a_d         = a_q;
        b_d         = b_q;
        eq_d        = eq_q;
        dwell_d     = dwell_q;
        passes_d    = passes_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        err_empty_d = 1'b0;
        do_load     = 1'b0;
        ld_idx      = '0;
        ld_entry    = entry_first;

        unique case (state_q)
            S_IDLE: begin
                // start outranks clear so a playback never begins on a table emptied that cycle
                if (bus.start) begin
                    if (count_q == '0) begin
                        err_empty_d = 1'b1;
                    end else begin
                        state_d  = S_PLAY;
                        passes_d = bus.repeat_cnt;
                        do_load  = 1'b1;
                    end
                end else if (bus.clear) begin
                    count_d = '0;
                end else if (wr_fire) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_PLAY: begin
                if (bus.stop) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else if (next_idx < count_q) begin
                    do_load  = 1'b1;
                    ld_idx   = next_idx[IDX_W-1:0];
                    ld_entry = entry_next;
                end else if (passes_q != '0) begin
                    passes_d = passes_q - REP_W'(1);
                    do_load  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_load) begin
            a_d        = ld_entry[ENTRY_W-1];
            b_d        = ld_entry[ENTRY_W-2];
            eq_d       = (ld_entry[ENTRY_W-1] == ld_entry[ENTRY_W-2]);
            dwell_d    = ld_entry[DWELL_W-1:0];
            step_idx_d = ld_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            step_idx_q  <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            eq_q        <= 1'b1;
            dwell_q     <= '0;
            passes_q    <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            step_idx_q  <= step_idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            eq_q        <= eq_d;
            dwell_q     <= dwell_d;
            passes_q    <= passes_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            err_empty_q <= err_empty_d;
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.eq_out    = eq_q;
    assign bus.busy      = (state_q == S_PLAY);
    assign bus.step_idx  = step_idx_q;
    assign bus.count     = count_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.err_empty = err_empty_q;
endmodule

// File: tb/tb_pair_pattern_driver.sv
// Randomized bench for pair_pattern_driver; expected waveforms are expanded from a
// table model (steps x dwell x passes) rather than from any cycle-level state machine.
module tb_pair_pattern_driver;
    localparam int DEPTH   = 8;
    localparam int DWELL_W = 8;
    localparam int REP_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;

    pair_pattern_driver_if #(.DEPTH(DEPTH), .DWELL_W(DWELL_W), .REP_W(REP_W)) bus ();

    pair_pattern_driver #(.DEPTH(DEPTH), .DWELL_W(DWELL_W), .REP_W(REP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // table model
    bit m_a [DEPTH];
    bit m_b [DEPTH];
    int m_d [DEPTH];
    int m_count = 0;

    typedef struct {
        bit a;
        bit b;
        int idx;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // eq_out must always agree with the driven pair in the same cycle
    always @(negedge clk) begin
        if (chk_en) check("eq_coherent", {31'd0, bus.eq_out}, {31'd0, bus.a_out == bus.b_out});
    end

    task automatic check_reset();
        check("rst_a", bus.a_out, 0);
        check("rst_b", bus.b_out, 0);
        check("rst_eq", bus.eq_out, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.count, 0);
        check("rst_step_idx", bus.step_idx, 0);
        check("rst_done", bus.done, 0);
        check("rst_aborted", bus.aborted, 0);
        check("rst_err_empty", bus.err_empty, 0);
    endtask

    task automatic write_step(input bit a, input bit b, input int d);
        bit exp_rdy;
        exp_rdy = (m_count < DEPTH);
        bus.wr_valid = 1'b1;
        bus.wr_a     = a;
        bus.wr_b     = b;
        bus.wr_dwell = DWELL_W'(d);
        #1;
        check("wr_ready", bus.wr_ready, exp_rdy);
        tick();
        bus.wr_valid = 1'b0;
        if (exp_rdy) begin
            m_a[m_count] = a;
            m_b[m_count] = b;
            m_d[m_count] = d;
            m_count++;
        end
        check("wr_count", bus.count, m_count);
        $display("write a=%0d b=%0d dwell=%0d accepted=%0d count=%0d", a, b, d, exp_rdy, bus.count);
    endtask

    // clear together with a write: the write must be dropped
    task automatic clear_table();
        bus.clear    = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_a     = 1'($urandom);
        bus.wr_b     = 1'($urandom);
        bus.wr_dwell = DWELL_W'($urandom_range(0, 3));
        tick();
        bus.clear    = 1'b0;
        bus.wr_valid = 1'b0;
        m_count = 0;
        check("clear_count", bus.count, 0);
        $display("clear count=%0d", bus.count);
    endtask

    // stop_mode: -1 no stop, -2 random, >=0 stop sampled at the end of that playback cycle
    task automatic run_play(input int rep, input int stop_mode, input bit noise);
        exp_t q[$];
        exp_t e;
        int   stop_at;
        bit   last_a, last_b;
        for (int p = 0; p <= rep; p++)
            for (int i = 0; i < m_count; i++)
                for (int k = 0; k <= m_d[i]; k++) begin
                    e.a = m_a[i]; e.b = m_b[i]; e.idx = i;
                    q.push_back(e);
                end
        stop_at = stop_mode;
        if (stop_mode == -2) stop_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, q.size() - 1));

        bus.start      = 1'b1;
        bus.repeat_cnt = REP_W'(rep);
        #1;
        check("wr_ready_start", bus.wr_ready, 0);
        tick();
        bus.start = 1'b0;
        last_a = q[0].a;
        last_b = q[0].b;
        for (int k = 0; k < q.size(); k++) begin
            check("play_busy", bus.busy, 1);
            check("play_a", bus.a_out, q[k].a);
            check("play_b", bus.b_out, q[k].b);
            check("play_eq", bus.eq_out, q[k].a == q[k].b);
            check("play_idx", bus.step_idx, q[k].idx);
            check("play_done", bus.done, 0);
            check("play_count", bus.count, m_count);
            last_a = q[k].a;
            last_b = q[k].b;
            if (k == stop_at) begin
                bus.stop = 1'b1;
                tick();
                bus.stop = 1'b0;
                check("stop_busy", bus.busy, 0);
                check("stop_aborted", bus.aborted, 1);
                check("stop_done", bus.done, 0);
                check("stop_a", bus.a_out, last_a);
                check("stop_b", bus.b_out, last_b);
                $display("play rep=%0d steps=%0d stopped at cycle %0d of %0d", rep, m_count, k, q.size());
                tick();
                check("stop_aborted_pulse", bus.aborted, 0);
                return;
            end
            if (noise) begin
                bus.clear    = 1'($urandom);
                bus.start    = 1'($urandom);
                bus.wr_valid = 1'($urandom);
            end
            tick();
            bus.clear    = 1'b0;
            bus.start    = 1'b0;
            bus.wr_valid = 1'b0;
        end
        check("end_done", bus.done, 1);
        check("end_busy", bus.busy, 0);
        check("end_aborted", bus.aborted, 0);
        check("end_a", bus.a_out, last_a);
        check("end_b", bus.b_out, last_b);
        check("end_count", bus.count, m_count);
        $display("play rep=%0d steps=%0d completed in %0d cycles", rep, m_count, q.size());
        tick();
        check("done_pulse", bus.done, 0);
        check("hold_a", bus.a_out, last_a);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_valid   = 1'b0;
        bus.wr_a       = 1'b0;
        bus.wr_b       = 1'b0;
        bus.wr_dwell   = '0;
        bus.clear      = 1'b0;
        bus.start      = 1'b0;
        bus.repeat_cnt = '0;
        bus.stop       = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        check_reset();
        rst = 1'b0;
        chk_en = 1'b1;

        // three-step table, single pass, then three passes with noise, then stop mid-step
        write_step(1, 1, 0);
        write_step(0, 1, 1);
        write_step(1, 0, 0);
        run_play(0, -1, 0);
        run_play(2, -1, 1);
        run_play(0, 2, 0);

        // start on an empty table
        clear_table();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("err_empty", bus.err_empty, 1);
        check("err_busy", bus.busy, 0);
        tick();
        check("err_empty_pulse", bus.err_empty, 0);
        check("err_busy2", bus.busy, 0);

        // overfill: the ninth write is refused
        for (int i = 0; i < 9; i++) write_step(1'($urandom), 1'($urandom), $urandom_range(0, 2));
        check("full_count", bus.count, DEPTH);
        run_play(0, -1, 1);

        // randomized tables
        for (int it = 0; it < 8; it++) begin
            int n;
            clear_table();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) write_step(1'($urandom), 1'($urandom), $urandom_range(0, 3));
            run_play($urandom_range(0, 2), -2, 1);
        end

        // stop while idle does nothing
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("idle_stop_aborted", bus.aborted, 0);
        check("idle_stop_busy", bus.busy, 0);

        // reset during playback
        bus.start      = 1'b1;
        bus.repeat_cnt = REP_W'(3);
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_reset();
        rst = 1'b0;
        m_count = 0;
        tick();
        check_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pair_pattern_driver.md
# pair_pattern_driver

Programmable stimulus source for paired signals checked by equality assertions. It stores a short table of (a, b, dwell) steps and plays them out on two registered outputs. Both outputs always change on the same clock edge, so a downstream `a == b` checker never sees an intermediate mismatch. It sits on the driving side of the pair-equality checkers: benches and self-test wrappers use it in place of ad-hoc procedural drives.

## Interface
- `DEPTH`, 8 — number of step entries in the table (≥2).
- `DWELL_W`, 8 — width of the per-step dwell field.
- `REP_W`, 4 — width of the repeat count.

Ports:
- `clk`  in  1  — single clock; all logic is on the rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `wr_valid`  in  1  — table write request.
- `wr_ready`  out  1  — `!busy && !start && count < DEPTH` (combinational).
- `wr_a`, `wr_b`  in  1 each — step values for `a_out` and `b_out`.
- `wr_dwell`  in  `DWELL_W` — extra hold cycles for the step.
- `clear`  in  1 — empties the table; ignored while `busy`.
- `start`  in  1 — begin playback.
- `repeat_cnt`  in  `REP_W` — extra passes; sampled at start.
- `stop`  in  1 — abort playback.
- `a_out`, `b_out`  out  1 each — driven pair, registered.
- `eq_out`  out  1 — registered `a_out == b_out`, coincident with the outputs.
- `busy`  out  1 — playback in progress.
- `step_idx`  out  `$clog2(DEPTH)` — index of the step currently driven.
- `count`  out  `$clog2(DEPTH)+1` — number of loaded steps.
- `done`  out  1 — one-cycle pulse when playback completes.
- `aborted`  out  1 — one-cycle pulse when `stop` takes effect.
- `err_empty`  out  1 — one-cycle pulse when `start` arrives with an empty table.

## Operation
- States: IDLE and PLAY.
- Reset values:
  - State IDLE; `count`, `step_idx`, `a_out`, `b_out` = 0.
  - `eq_out` = 1.
  - `busy`, `done`, `aborted`, `err_empty` = 0.
  - Table contents are don't-care.
- IDLE, write: when `wr_valid && wr_ready`, store {`wr_a`, `wr_b`, `wr_dwell`} at index `count`, then increment `count`.
  - A write attempted at `count == DEPTH` is not accepted; the table is unchanged.
- IDLE, `clear`:
  - `count` := 0.
  - If `clear` and a write occur in the same cycle, `clear` wins and the write is dropped.
- IDLE, `start` with `count == 0`: pulse `err_empty` and stay in IDLE.
- IDLE, `start` with `count > 0`:
  - Go to PLAY.
  - Latch `passes_left := repeat_cnt`.
  - Load step 0 into `a_out`/`b_out`/`eq_out`; `step_idx` := 0.
  - Load the dwell counter with step 0's dwell.
- PLAY, step hold: each step is held for `dwell + 1` cycles, so `dwell = 0` holds for one cycle. On the last cycle of the current step:
  - Next index < `count`: load that step.
  - Else if `passes_left > 0`: decrement `passes_left`, wrap to step 0 and load it.
  - Else: return to IDLE and pulse `done`. Outputs hold the last step's values.
- PLAY, ignored inputs: `start` is ignored; `wr_ready` is 0; `clear` is ignored.
- PLAY, `stop`:
  - Return to IDLE the next cycle and pulse `aborted`; `done` is not pulsed.
  - Outputs hold their current values.
  - `stop` has priority over a step advance in the same cycle.
- `stop` in IDLE has no effect.
- `a_out`, `b_out` and `eq_out` are always written by the same register update, so they are never skewed by a cycle.
- Arithmetic:
  - The dwell counter is `DWELL_W` bits and counts down to 0; there is no wrap.
  - The passes counter is `REP_W` bits.
  - Total passes = `repeat_cnt + 1`.
- `rst` asserted mid-playback: the next edge restores all reset values, and the table is emptied (`count` = 0).

## Timing
- `start` sampled at edge T:
  - `busy = 1` and step 0 appears on the outputs after edge T.
  - `step_idx` tracks the driven step in the same cycle.
- Playback length:
  - Per pass: `sum(dwell_i + 1)` cycles.
  - Total: `(repeat_cnt + 1) × sum`.
- `done`, `busy`:
  - `done` is high and `busy` is low in the cycle immediately after the final cycle of the last step.
  - `done` lasts one cycle.
- `stop` sampled at edge S: `busy = 0` and `aborted = 1` in the following cycle.
- `err_empty`: asserted for the one cycle after `start` is sampled.
- `wr_ready` responds combinationally to `busy`, `start` and `count`; a write has zero latency into `count`, visible the next cycle.

## Test plan
- Load three steps (1,1,d0), (0,1,d1), (1,0,d0), `repeat_cnt` = 0, `start` at cycle 0. Required response:
  - Cycle 1: `a_out`/`b_out`/`eq_out` = 1/1/1.
  - Cycles 2–3: 0/1/0.
  - Cycle 4: 1/0/0.
  - Cycle 5: `done` = 1, `busy` = 0, outputs stay 1/0.
- Same table with `repeat_cnt` = 2: 12 busy cycles, `step_idx` wraps 2→0 twice, exactly one `done` pulse.
- Write 9 entries with `DEPTH` = 8: the 9th write sees `wr_ready` = 0, `count` = 8; playback shows only the first 8.
- `start` with `count` = 0: `err_empty` pulse, `busy` stays 0; then `clear` during PLAY leaves `count` unchanged.
- `stop` in the second cycle of the (0,1,d1) step: next cycle `busy` = 0, `aborted` = 1, outputs stay 0/1, no `done`.
- Assert `rst` mid-playback: next cycle all outputs are at reset values, `count` = 0, `eq_out` = 1; an `a_out == b_out` deferred check against `eq_out` passes on every cycle.
